// File: rtl/segment_capture.sv
// segment_capture
//   Receive-side monitor for a multiplexed seven-segment display bus. The
//   segment and digit-select lines are synchronized, a pattern must hold
//   steady before it is accepted, each accepted pattern is decoded back to a
//   hex nibble and stored per digit, and once every digit has been written
//   the assembled frame is published on data_out with a one-cycle
//   frame_valid pulse.
//
// Parameters
//   DIGITS        number of multiplexed digits (2..8)
//   STABLE_CYCLES consecutive identical samples needed before a commit (1..255)
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   segment      segment lines a..g on bits 0..6, active-high
//   digit_sel    digit enables, active-high, expected one-hot
//   err_clr      synchronous clear of err_sticky
//   data_out     last complete frame, digit i at bits [4i+3:4i]
//   frame_valid  one-cycle pulse when data_out updates
//   err_sticky   set by an illegal stable pattern
//
// Optional feature (macro SEGMENT_CAPTURE_DP_EN)
//   seg_dp       decimal-point line, synchronized and compared with the others
//   dp_out       captured decimal point per digit, loaded with data_out

module segment_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            segment,
  input  logic [DIGITS-1:0]     digit_sel,
`ifdef SEGMENT_CAPTURE_DP_EN
  input  logic                  seg_dp,
  output logic [DIGITS-1:0]     dp_out,
`endif
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   data_out,
  output logic                  frame_valid,
  output logic                  err_sticky
);

`ifdef SEGMENT_CAPTURE_DP_EN
  localparam int DPW = 1;
`else
  localparam int DPW = 0;
`endif
  localparam int W  = DIGITS + 7 + DPW;
  localparam int IW = $clog2(DIGITS);
  localparam logic [7:0]        CNT_MAX    = 8'(STABLE_CYCLES);
  localparam logic [7:0]        CNT_COMMIT = 8'(STABLE_CYCLES - 1);
  localparam logic [DIGITS-1:0] SEL_ONE    = DIGITS'(1);
  localparam logic [DIGITS-1:0] MASK_FULL  = {DIGITS{1'b1}};

  logic [W-1:0]        busIn;
  logic [W-1:0]        sync1_q, sync2_q, prev_q;
  logic [7:0]          cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [4*DIGITS-1:0] dataOut_q;
  logic                frameValid_q;
  logic                err_q, err_d;

  logic [6:0]          segS2;
  logic [DIGITS-1:0]   selS2;
  logic                same, commit;
  logic                selZero, selOneHot;
  logic                decValid;
  logic [3:0]          decNibble;
  logic [IW-1:0]       digitIdx;
  logic                writeEn, errSet, frameDone;
  logic [DIGITS-1:0]   maskSet;

`ifdef SEGMENT_CAPTURE_DP_EN
  logic [DIGITS-1:0]   shadowDp_q, shadowDp_d;
  logic [DIGITS-1:0]   dpOut_q;
  assign busIn = {seg_dp, digit_sel, segment};
`else
  assign busIn = {digit_sel, segment};
`endif

  assign segS2 = sync2_q[6:0];
  assign selS2 = sync2_q[7 +: DIGITS];

  // Inverse of the driver's encoding table; bit 4 flags a legal glyph.
  function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
    case (seg)
      7'h3F: return {1'b1, 4'h0};
      7'h06: return {1'b1, 4'h1};
      7'h5B: return {1'b1, 4'h2};
      7'h4F: return {1'b1, 4'h3};
      7'h66: return {1'b1, 4'h4};
      7'h6D: return {1'b1, 4'h5};
      7'h7D: return {1'b1, 4'h6};
      7'h07: return {1'b1, 4'h7};
      7'h7F: return {1'b1, 4'h8};
      7'h6F: return {1'b1, 4'h9};
      7'h77: return {1'b1, 4'hA};
      7'h7C: return {1'b1, 4'hB};
      7'h39: return {1'b1, 4'hC};
      7'h5E: return {1'b1, 4'hD};
      7'h79: return {1'b1, 4'hE};
      7'h71: return {1'b1, 4'hF};
      default: return 5'b0_0000;
    endcase
  endfunction

  always_comb begin
    same = (sync2_q == prev_q);

    // Counter saturates so a long dwell commits exactly once, on the edge
    // where it would step from STABLE_CYCLES-1 to STABLE_CYCLES.
    if (!same)                cnt_d = 8'd0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 8'd1;
    commit = same && (cnt_q == CNT_COMMIT);

    selZero   = (selS2 == '0);
    selOneHot = !selZero && ((selS2 & (selS2 - SEL_ONE)) == '0);
    {decValid, decNibble} = decodeSeg(segS2);

    digitIdx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (selS2[i]) digitIdx = i[IW-1:0];
    end

    // A blank glyph (7'h00) is not in the table, so it neither writes nor
    // errors; only non-zero unknown glyphs are illegal.
    writeEn = commit && selOneHot && decValid;
    errSet  = commit && !selZero &&
              (!selOneHot || ((segS2 != 7'h00) && !decValid));

    shadow_d = shadow_q;
    if (writeEn) shadow_d[4*digitIdx +: 4] = decNibble;

    maskSet   = mask_q | (SEL_ONE << digitIdx);
    frameDone = writeEn && (maskSet == MASK_FULL);
    mask_d    = mask_q;
    if (writeEn) mask_d = frameDone ? '0 : maskSet;

    // A new error on the same edge as err_clr must survive.
    if (errSet)       err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

`ifdef SEGMENT_CAPTURE_DP_EN
  always_comb begin
    shadowDp_d = shadowDp_q;
    if (writeEn) shadowDp_d[digitIdx] = sync2_q[W-1];
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      mask_q       <= '0;
      dataOut_q    <= '0;
      frameValid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync1_q      <= busIn;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      mask_q       <= mask_d;
      frameValid_q <= frameDone;
      err_q        <= err_d;
      if (frameDone) dataOut_q <= shadow_d;
    end
  end

`ifdef SEGMENT_CAPTURE_DP_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadowDp_q <= '0;
      dpOut_q    <= '0;
    end else begin
      shadowDp_q <= shadowDp_d;
      if (frameDone) dpOut_q <= shadowDp_d;
    end
  end

  assign dp_out = dpOut_q;
`endif

  assign data_out    = dataOut_q;
  assign frame_valid = frameValid_q;
  assign err_sticky  = err_q;

endmodule

// File: tb/tb_segment_capture.sv
// tb_segment_capture
//   Directed bench for segment_capture with DIGITS=4, STABLE_CYCLES=4.
//   Inputs change just after a falling edge and are held for a whole number
//   of rising edges; outputs are observed on falling edges.

module tb_segment_capture;

  logic        clock;
  logic        reset;
  logic [6:0]  segment;
  logic [3:0]  digit_sel;
  logic        err_clr;
  logic [15:0] data_out;
  logic        frame_valid;
  logic        err_sticky;
`ifdef SEGMENT_CAPTURE_DP_EN
  logic        segDp;
  logic [3:0]  dp_out;
`endif

  int compared   = 0;
  int mismatched = 0;
  int cycleCount = 0;
  int fvCount    = 0;
  int fvCycle    = 0;
  int fvBase;
  int startCycle;

  segment_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .segment     (segment),
    .digit_sel   (digit_sel),
`ifdef SEGMENT_CAPTURE_DP_EN
    .seg_dp      (segDp),
    .dp_out      (dp_out),
`endif
    .err_clr     (err_clr),
    .data_out    (data_out),
    .frame_valid (frame_valid),
    .err_sticky  (err_sticky)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cycleCount++;

  // Frame pulses are tallied so tests can tell how many frames appeared.
  always @(negedge clock) begin
    if (reset && frame_valid) begin
      fvCount++;
      fvCycle = cycleCount;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one select/segment pattern for the given number of rising edges.
  task automatic applyStimulus(input logic [3:0] sel, input logic [6:0] seg,
                               input int edges);
    digit_sel = sel;
    segment   = seg;
    repeat (edges) @(negedge clock);
  endtask

  task automatic pulseErrClr();
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    segment   = 7'h00;
    digit_sel = 4'b0000;
    err_clr   = 1'b0;
`ifdef SEGMENT_CAPTURE_DP_EN
    segDp     = 1'b0;
`endif
    repeat (2) @(negedge clock);
    checkOutput("reset_data", 32'(data_out), 32'h0);
    checkOutput("reset_fv", 32'(frame_valid), 32'h0);
    checkOutput("reset_err", 32'(err_sticky), 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Basic scan 1,2,3,4 and commit latency of the final digit.
    fvBase = fvCount;
    applyStimulus(4'b0001, 7'h06, 8);
    applyStimulus(4'b0010, 7'h5B, 8);
    applyStimulus(4'b0100, 7'h4F, 8);
    startCycle = cycleCount;
    applyStimulus(4'b1000, 7'h66, 8);
    checkOutput("scan_frames", 32'(fvCount - fvBase), 32'd1);
    checkOutput("scan_latency", 32'(fvCycle - startCycle), 32'd7);
    checkOutput("scan_data", 32'(data_out), 32'h4321);

    // A 4-clock glitch of '0' on digit 0 must not land before '8' does.
    fvBase = fvCount;
    applyStimulus(4'b0010, 7'h77, 8);
    applyStimulus(4'b0100, 7'h7C, 8);
    applyStimulus(4'b1000, 7'h39, 8);
    applyStimulus(4'b0001, 7'h3F, 4);
    applyStimulus(4'b0001, 7'h7F, 8);
    checkOutput("glitch_data", 32'(data_out), 32'hCBA8);
    checkOutput("glitch_frames", 32'(fvCount - fvBase), 32'd1);

    // Illegal glyph on a valid digit sets the sticky error.
    fvBase = fvCount;
    applyStimulus(4'b0001, 7'h49, 8);
    checkOutput("illegal_err", 32'(err_sticky), 32'h1);
    checkOutput("illegal_nofv", 32'(fvCount - fvBase), 32'd0);
    checkOutput("illegal_data", 32'(data_out), 32'hCBA8);
    pulseErrClr();
    checkOutput("illegal_clr", 32'(err_sticky), 32'h0);

    // Non-one-hot select, then an error colliding with err_clr.
    applyStimulus(4'b0011, 7'h06, 8);
    checkOutput("multisel_err", 32'(err_sticky), 32'h1);
    applyStimulus(4'b0101, 7'h06, 6);
    pulseErrClr();
    checkOutput("clr_collide_err", 32'(err_sticky), 32'h1);
    applyStimulus(4'b0101, 7'h06, 2);
    pulseErrClr();
    checkOutput("collide_clr", 32'(err_sticky), 32'h0);

    // Blanking and blank glyph produce neither writes nor errors.
    applyStimulus(4'b0000, 7'h49, 20);
    checkOutput("blank_sel_err", 32'(err_sticky), 32'h0);
    applyStimulus(4'b0001, 7'h00, 8);
    checkOutput("blank_seg_err", 32'(err_sticky), 32'h0);

    // Frame 0,0,5,9 written high digit first; no stray mask bits allowed.
    fvBase = fvCount;
    applyStimulus(4'b1000, 7'h6F, 8);
    applyStimulus(4'b0100, 7'h6D, 8);
    applyStimulus(4'b0010, 7'h3F, 8);
    checkOutput("partial_nofv", 32'(fvCount - fvBase), 32'd0);
    applyStimulus(4'b0001, 7'h3F, 8);
    checkOutput("frame9500_data", 32'(data_out), 32'h9500);
    checkOutput("frame9500_count", 32'(fvCount - fvBase), 32'd1);

    // Reset in the middle of a partial frame.
    applyStimulus(4'b0001, 7'h06, 8);
    applyStimulus(4'b0010, 7'h5B, 8);
    applyStimulus(4'b0100, 7'h4F, 8);
    reset = 1'b0;
    #1;
    checkOutput("midreset_data", 32'(data_out), 32'h0);
    checkOutput("midreset_fv", 32'(frame_valid), 32'h0);
    checkOutput("midreset_err", 32'(err_sticky), 32'h0);
    digit_sel = 4'b0000;
    segment   = 7'h00;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    fvBase = fvCount;
    applyStimulus(4'b1000, 7'h07, 8);
    checkOutput("postreset_nofv", 32'(fvCount - fvBase), 32'd0);
    applyStimulus(4'b0001, 7'h79, 8);
    applyStimulus(4'b0010, 7'h5E, 8);
    applyStimulus(4'b0100, 7'h71, 8);
    checkOutput("postreset_data", 32'(data_out), 32'h7FDE);
    checkOutput("postreset_count", 32'(fvCount - fvBase), 32'd1);

`ifdef SEGMENT_CAPTURE_DP_EN
    // Decimal point set only while digit 2 is shown.
    applyStimulus(4'b0001, 7'h06, 8);
    applyStimulus(4'b0010, 7'h06, 8);
    segDp = 1'b1;
    applyStimulus(4'b0100, 7'h06, 8);
    segDp = 1'b0;
    applyStimulus(4'b1000, 7'h06, 8);
    checkOutput("dp_out", 32'(dp_out), 32'h4);
    checkOutput("dp_data", 32'(data_out), 32'h1111);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
